// File: rtl/alu_cmd_sequencer.sv
// Three-address ALU command sequencer: decodes packed commands, reads operands from a
// local register file, drives an external ALU via start/done and writes the result back.
module alu_cmd_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OP_W+3*ADDR_W-1:0]   cmd,
    output logic [OP_W-1:0]            alu_op_code,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic                       alu_start,
    input  logic                       alu_done,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic [CNT_W-1:0]           exec_count,
    output logic [CNT_W-1:0]           nop_count
);
    localparam int CMD_W = OP_W + 3*ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    localparam logic [OP_W-1:0] OP_NOT = OP_W'(4);

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] result;

    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_a1;
    logic [ADDR_W-1:0] cmd_a2;
    logic [ADDR_W-1:0] cmd_a3;
    logic              cmd_is_alu;
    logic              accept;

    assign cmd_op     = cmd[CMD_W-1 -: OP_W];
    assign cmd_a1     = cmd[3*ADDR_W-1 -: ADDR_W];
    assign cmd_a2     = cmd[2*ADDR_W-1 -: ADDR_W];
    assign cmd_a3     = cmd[ADDR_W-1:0];
    assign cmd_is_alu = (cmd_op <= OP_NOT);

    assign cmd_ready  = rst_n && (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign alu_start  = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);
    assign rd_data    = mem[rd_addr];

    // Operands are captured at accept so later loads or write-backs cannot disturb them;
    // a done arriving during ISSUE is taken immediately to support zero-latency ALUs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            alu_op_code <= '1;
            alu_a       <= '0;
            alu_b       <= '0;
            dst         <= '0;
            result      <= '0;
            exec_count  <= '0;
            nop_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_is_alu) begin
                            state       <= ST_ISSUE;
                            alu_op_code <= cmd_op;
                            dst         <= cmd_a3;
                            alu_a       <= mem[cmd_a1];
                            alu_b       <= (cmd_op == OP_NOT) ? '0 : mem[cmd_a2];
                        end else begin
                            nop_count <= nop_count + CNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (alu_done) begin
                        result <= alu_result;
                        state  <= ST_WB;
                    end else begin
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        result <= alu_result;
                        state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    exec_count  <= exec_count + CNT_W'(1);
                    alu_op_code <= '1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-back is the later assignment so it wins over a host load to the same address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ld_valid) begin
                mem[ld_addr] <= ld_data;
            end
            if (state == ST_WB) begin
                mem[dst] <= result;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd = '0;
    logic [2:0]  alu_op_code;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = '0;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic [15:0] exec_count;
    logic [15:0] nop_count;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit check_en   = 1'b0;
    int acc_cyc    = 0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .exec_count(exec_count), .nop_count(nop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return ~a;
        endcase
    endfunction

    // External ALU: answers alu_start after alu_latency extra cycles (0 = same cycle)
    int          alu_latency = 0;
    int          lat_cnt     = 0;
    logic        pend        = 1'b0;
    logic [31:0] pend_res    = '0;
    int          start_cnt   = 0;
    logic [2:0]  last_op     = '0;
    logic [31:0] last_a      = '0;
    logic [31:0] last_b      = '0;

    always @(negedge clk) begin
        alu_done = 1'b0;
        if (alu_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            last_op   = alu_op_code;
            last_a    = alu_a;
            last_b    = alu_b;
            pend_res  = alu_fn(alu_op_code, alu_a, alu_b);
            pend      = 1'b1;
            lat_cnt   = alu_latency;
        end
        if (pend) begin
            if (lat_cnt == 0) begin
                alu_done   = 1'b1;
                alu_result = pend_res;
                pend       = 1'b0;
            end else begin
                lat_cnt = lat_cnt - 1;
            end
        end
    end

    // Transaction-level model: one in-flight op from accept until its result is written back
    logic        m_inflight = 1'b0;
    logic        m_issued   = 1'b0;
    logic        m_have_res = 1'b0;
    logic [2:0]  m_op       = 3'b111;
    logic [31:0] m_a        = '0;
    logic [31:0] m_b        = '0;
    logic [31:0] m_res      = '0;
    logic [2:0]  m_dst      = '0;
    logic [15:0] m_exec     = '0;
    logic [15:0] m_nop      = '0;
    logic [31:0] m_mem [8];
    logic        m_wb;
    logic [31:0] opa;
    logic [31:0] opb;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_inflight = 1'b0;
            m_issued   = 1'b0;
            m_have_res = 1'b0;
            m_op       = 3'b111;
            m_exec     = '0;
            m_nop      = '0;
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
        end else begin
            m_wb = m_inflight && m_have_res;
            opa  = m_mem[cmd[8:6]];
            opb  = (cmd[11:9] == 3'd4) ? 32'd0 : m_mem[cmd[5:3]];
            if (ld_valid && !(m_wb && ld_addr == m_dst)) m_mem[ld_addr] = ld_data;
            if (m_wb) begin
                m_mem[m_dst] = m_res;
                m_exec       = m_exec + 16'd1;
                m_inflight   = 1'b0;
                m_have_res   = 1'b0;
                m_op         = 3'b111;
            end else if (m_inflight) begin
                if (!m_have_res && alu_done) begin
                    m_res      = alu_result;
                    m_have_res = 1'b1;
                end
                m_issued = 1'b1;
            end else if (cmd_valid) begin
                if (cmd[11:9] <= 3'd4) begin
                    m_inflight = 1'b1;
                    m_issued   = 1'b0;
                    m_op       = cmd[11:9];
                    m_a        = opa;
                    m_b        = opb;
                    m_dst      = cmd[2:0];
                end else begin
                    m_nop = m_nop + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cmd_ready",   32'(cmd_ready),   32'(rst_n && !m_inflight));
            checkOutput("alu_start",   32'(alu_start),   32'(m_inflight && !m_issued));
            checkOutput("busy",        32'(busy),        32'(m_inflight));
            checkOutput("alu_op_code", 32'(alu_op_code), 32'(m_op));
            checkOutput("exec_count",  32'(exec_count),  32'(m_exec));
            checkOutput("nop_count",   32'(nop_count),   32'(m_nop));
            checkOutput("rd_data",     rd_data,          m_mem[rd_addr]);
            if (m_inflight) begin
                checkOutput("alu_a", alu_a, m_a);
                checkOutput("alu_b", alu_b, m_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_addr = rd_addr + 3'd1;
    endtask

    task automatic load(input logic [2:0] addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [2:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        checkOutput(name, rd_data, exp);
    endtask

    // Offers a command and holds it until accepted; returns 1 time unit after the accept edge
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2,
                                 input logic [2:0] a3);
        bit accepted = 1'b0;
        bit rdy;
        cmd       = {op, a1, a2, a3};
        cmd_valid = 1'b1;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            rdy = (cmd_ready === 1'b1);
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
        end
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int t0;
        int c1;
        int c2;
        int c3;
        int s0;

        // Reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        checkOutput("rst_op_code", 32'(alu_op_code), 32'd7);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_exec", 32'(exec_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);

        // ADD r3 = r1 + r2 with a zero-latency ALU
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        s0 = start_cnt;
        applyStimulus(3'd0, 3'd1, 3'd2, 3'd3);
        tick();
        checkOutput("ready_in_wb", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("ready_after_3", 32'(cmd_ready), 32'd1);
        checkOutput("add_start_pulses", 32'(start_cnt - s0), 32'd1);
        checkOutput("add_a", last_a, 32'd5);
        checkOutput("add_b", last_b, 32'd3);
        checkOutput("add_op", 32'(last_op), 32'd0);
        peek("add_r3", 3'd3, 32'd8);
        checkOutput("model_r3", m_mem[3], 32'd8);
        checkOutput("add_exec", 32'(exec_count), 32'd1);

        // NOT is unary: alu_b forced to zero even when addr2 points at a nonzero register
        load(3'd4, 32'hFFFF0000);
        applyStimulus(3'd4, 3'd4, 3'd0, 3'd5);
        wait_idle();
        checkOutput("not_b", last_b, 32'd0);
        checkOutput("not_op", 32'(last_op), 32'd4);
        peek("not_r5", 3'd5, 32'h0000FFFF);
        applyStimulus(3'd4, 3'd4, 3'd1, 3'd6);
        wait_idle();
        checkOutput("not_b_nz_src", last_b, 32'd0);
        peek("not_r6", 3'd6, 32'h0000FFFF);

        // Slow ALU with a second command waiting behind it
        load(3'd6, 32'd100);
        load(3'd7, 32'd23);
        alu_latency = 7;
        applyStimulus(3'd0, 3'd6, 3'd7, 3'd0);
        t0 = acc_cyc;
        applyStimulus(3'd5, 3'd0, 3'd0, 3'd0);
        checkOutput("slow_accept_gap", 32'(acc_cyc - t0), 32'd10);
        alu_latency = 0;
        peek("slow_r0", 3'd0, 32'd123);
        checkOutput("model_r0", m_mem[0], 32'd123);

        // SUB overwriting a source, then RAW through write-back
        load(3'd1, 32'd10);
        load(3'd2, 32'd4);
        applyStimulus(3'd1, 3'd1, 3'd2, 3'd1);
        wait_idle();
        peek("sub_r1", 3'd1, 32'd6);
        applyStimulus(3'd0, 3'd1, 3'd2, 3'd3);
        wait_idle();
        checkOutput("raw_a", last_a, 32'd6);
        peek("raw_r3", 3'd3, 32'd10);

        // Back-to-back NOPs
        s0 = start_cnt;
        applyStimulus(3'd5, 3'd1, 3'd2, 3'd3);
        c1 = acc_cyc;
        applyStimulus(3'd6, 3'd1, 3'd2, 3'd3);
        c2 = acc_cyc;
        applyStimulus(3'd7, 3'd1, 3'd2, 3'd3);
        c3 = acc_cyc;
        checkOutput("nop_gap1", 32'(c2 - c1), 32'd1);
        checkOutput("nop_gap2", 32'(c3 - c2), 32'd1);
        checkOutput("nop_count", 32'(nop_count), 32'd4);
        checkOutput("nop_no_start", 32'(start_cnt - s0), 32'd0);
        peek("nop_r3", 3'd3, 32'd10);

        // Host load to r3 in the same cycle as write-back to r3
        applyStimulus(3'd1, 3'd1, 3'd2, 3'd3);
        tick();
        ld_valid = 1'b1;
        ld_addr  = 3'd3;
        ld_data  = 32'hDEADBEEF;
        tick();
        ld_valid = 1'b0;
        peek("wb_beats_ld", 3'd3, 32'd2);
        checkOutput("exec_total", 32'(exec_count), 32'd7);

        // Reset during WAIT; the ALU answers long after release
        alu_latency = 20;
        applyStimulus(3'd0, 3'd1, 3'd2, 3'd4);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        alu_latency = 0;
        checkOutput("late_done_fired", 32'(pend), 32'd0);
        for (int a = 0; a < 8; a++) peek("rst_reg_zero", 3'(a), 32'd0);
        checkOutput("rst2_exec", 32'(exec_count), 32'd0);
        checkOutput("rst2_nop", 32'(nop_count), 32'd0);
        checkOutput("rst2_op_code", 32'(alu_op_code), 32'd7);
        checkOutput("rst2_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst2_busy", 32'(busy), 32'd0);

        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Parametrised command sequencer that decodes packed three-address ALU commands and reads operands from an internal register file.
It issues each operation to an external ALU with a start/done handshake and writes the result back to the destination register.
It adds the following over the first-generation decoder: write-back, a command valid/ready handshake, multi-cycle ALU support, a host load port, a debug read port and status counters.
It sits between the command source and the ALU.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 3, register address width; register file depth = 2**ADDR_W
OP_W, 3, opcode width; CMD_W = OP_W + 3*ADDR_W (12 at defaults)
CNT_W, 16, width of the status counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd  in  CMD_W  {opcode, addr1, addr2, addr3}, opcode in the MSBs
alu_op_code  out  OP_W  operation to ALU
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
alu_start  out  1  one-cycle issue pulse
alu_done  in  1  ALU result valid (single-cycle pulse)
alu_result  in  DATA_W  ALU result, sampled when alu_done=1
ld_valid  in  1  host register write
ld_addr  in  ADDR_W  host write address
ld_data  in  DATA_W  host write data
rd_addr  in  ADDR_W  debug read address
rd_data  out  DATA_W  combinational mem[rd_addr]
busy  out  1  FSM not in IDLE
exec_count  out  CNT_W  ALU ops completed (wraps)
nop_count  out  CNT_W  NOP commands accepted (wraps)

Behaviour:
- Reset (rst_n=0 at clk edge, takes priority over everything):
  - all registers cleared to 0; FSM to IDLE
  - outputs: alu_op_code=3'b111, alu_a=0, alu_b=0, alu_start=0, busy=0, counters=0
  - cmd_ready=0 while rst_n=0; it may go high on the first cycle after release
  - reset mid-operation abandons the op: no write-back, a late alu_done is ignored
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT (unary, alu_b driven 0); 101/110/111 NOP.
- FSM states and transitions:
  - IDLE: cmd_ready=1.
    - On cmd_valid&cmd_ready with a valid ALU opcode: latch addr3 and opcode; latch alu_a=mem[addr1], alu_b=mem[addr2] (0 for NOT), sampled in the same cycle. Go to ISSUE.
    - On a NOP: nop_count++, stay in IDLE, no ALU activity.
  - ISSUE: alu_start=1 for exactly this cycle; alu_op_code/alu_a/alu_b held stable. Go to WAIT. An alu_done arriving in the ISSUE cycle is accepted as if in WAIT (zero-latency ALU).
  - WAIT: hold ALU outputs. On alu_done, capture alu_result and go to WB. No timeout.
  - WB: mem[addr3] <= captured result; exec_count++. Go to IDLE; alu_op_code returns to 3'b111.
- Throughput:
  - ALU op, zero-latency ALU: accept→IDLE again = 3 cycles; back-to-back accepts every 3 cycles.
  - NOP: back-to-back accepts every cycle.
- Operand hazards:
  - addr3 equal to addr1 or addr2 is legal; operands are captured at accept, so the result overwrites a source safely.
  - A following command reads the written-back value, since WB completes before IDLE.
- Load port: ld_valid writes mem[ld_addr]<=ld_data in any state. If ld_valid and WB target the same address in the same cycle, WB wins. A load to a source register after accept does not affect the in-flight operands.
- rd_data: combinational read of the current registered contents (no write-through).
- Counters wrap modulo 2**CNT_W.
- cmd held while cmd_ready=0 is not consumed; cmd_valid has no ordering requirement.

Test Plan:
- Load r1=5, r2=3; cmd ADD {000,001,010,011}, alu_done in the ISSUE cycle (ALU model result 8) → alu_start pulses once with alu_a=5, alu_b=3, alu_op_code=000; rd_addr=3 reads 8; exec_count=1; cmd_ready back high 3 cycles after accept.
- Load r4=0xFFFF0000; cmd NOT {100,100,000,101} → alu_b=0, alu_op_code=100; ALU model returns 0x0000FFFF; r5=0x0000FFFF.
- ALU done delayed 7 cycles; offer a second command during WAIT → cmd_ready=0 throughout, alu_op_code/alu_a/alu_b stable, second command accepted only after WB.
- SUB r1=r1-r2 (r1=10, r2=4): ALU model returns 6 → r1=6. Then ADD r1+r2 → alu_a=6 (RAW through write-back).
- Three NOP commands (101, 110, 111) back-to-back → accepted on consecutive cycles, nop_count=3, alu_start never asserted, registers unchanged.
- Assert rst_n=0 during WAIT, then pulse alu_done after release → no write-back, all regs 0, exec_count=0, alu_op_code=111, cmd_ready=1.
- Same-cycle ld_valid and WB to r3 → r3 holds the ALU result.
